// File: rtl/pa_pkg.sv
// rtl/pa_pkg.sv - shared types and constants for the PA sequencer
package pa_pkg;

    localparam int DW = 4;

    // Opcode encodings must match the alu in top
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_CAPT  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } pa_state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - step prescaler, one-cycle tick after TICK_DIV enabled cycles since clear
module tick_gen #(
    parameter int TICK_DIV = 125_000_000
) (
    input  logic sysclk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge sysclk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pa_sequencer.sv
// rtl/pa_sequencer.sv - drives the shared ALU to emit an arithmetic progression, one term per step
module pa_sequencer
    import pa_pkg::*;
#(
    parameter int TICK_DIV = 125_000_000
) (
    input  logic          sysclk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] n_terms,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_f,
    output logic [DW-1:0] term,
    output logic [DW-1:0] index,
    output logic          term_valid,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    pa_state_t     state, state_d;
    logic [2:0]    op_d;
    logic [DW-1:0] a_d, b_d, term_d, index_d;
    logic [DW-1:0] r_q, r_d, n_q, n_d, count, count_d;
    logic          tv_d, ovf_d, presc_clr, tick;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .sysclk (sysclk),
        .rst    (rst),
        .clr    (presc_clr),
        .en     (state == S_WAIT),
        .tick   (tick)
    );

    assign busy = (state == S_ISSUE) || (state == S_CAPT) || (state == S_WAIT);
    assign done = (state == S_DONE);

    always_comb begin
        state_d   = state;
        op_d      = alu_op;
        a_d       = alu_a;
        b_d       = alu_b;
        term_d    = term;
        index_d   = index;
        tv_d      = 1'b0;
        ovf_d     = ovf;
        r_d       = r_q;
        n_d       = n_q;
        count_d   = count;
        presc_clr = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    r_d     = r;
                    n_d     = n_terms;
                    ovf_d   = 1'b0;
                    index_d = '0;
                    count_d = '0;
                    op_d    = OP_PASS;
                    b_d     = '0;
                    if (n_terms == '0) begin
                        state_d = S_DONE;
                        a_d     = '0;
                    end else begin
                        state_d = S_ISSUE;
                        a_d     = a0;
                    end
                end
            end
            S_ISSUE: begin
                // ALU output is valid within this cycle; capture at its closing edge
                term_d  = alu_f;
                tv_d    = 1'b1;
                state_d = S_CAPT;
                if (alu_op == OP_ADD) begin
                    index_d = index + DW'(1);
                    if (({1'b0, term} + {1'b0, r_q}) > 5'd15) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_CAPT: begin
                count_d = count + DW'(1);
                if (count_d == n_q) begin
                    state_d = S_DONE;
                    op_d    = OP_PASS;
                    a_d     = '0;
                    b_d     = '0;
                end else begin
                    state_d   = S_WAIT;
                    presc_clr = 1'b1;
                end
            end
            S_WAIT: begin
                if (tick) begin
                    state_d = S_ISSUE;
                    op_d    = OP_ADD;
                    a_d     = term;
                    b_d     = r_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state      <= S_IDLE;
            alu_op     <= OP_PASS;
            alu_a      <= '0;
            alu_b      <= '0;
            term       <= '0;
            index      <= '0;
            term_valid <= 1'b0;
            ovf        <= 1'b0;
            r_q        <= '0;
            n_q        <= '0;
            count      <= '0;
        end else begin
            state      <= state_d;
            alu_op     <= op_d;
            alu_a      <= a_d;
            alu_b      <= b_d;
            term       <= term_d;
            index      <= index_d;
            term_valid <= tv_d;
            ovf        <= ovf_d;
            r_q        <= r_d;
            n_q        <= n_d;
            count      <= count_d;
        end
    end

endmodule

// File: tb/tb_pa_sequencer.sv
// tb/tb_pa_sequencer.sv - directed self-checking bench for pa_sequencer
module tb_pa_sequencer;
    import pa_pkg::*;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a0 = '0, r = '0, n_terms = '0;
    logic [2:0] alu_op;
    logic [3:0] alu_a, alu_b, alu_f, term, index;
    logic       term_valid, busy, done, ovf;

    int total = 0;
    int bad = 0;

    always #5 sysclk = ~sysclk;

    // Reference 4-bit ALU as it sits in top
    always_comb begin
        case (alu_op)
            OP_PASS: alu_f = alu_a;
            OP_ADD:  alu_f = alu_a + alu_b;
            default: alu_f = 4'h0;
        endcase
    end

    pa_sequencer #(.TICK_DIV(4)) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .start      (start),
        .a0         (a0),
        .r          (r),
        .n_terms    (n_terms),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .term       (term),
        .index      (index),
        .term_valid (term_valid),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input string tag, input int gap, input logic [3:0] et,
                              input logic [3:0] ei, input logic eo);
        int cyc = 0;
        do begin
            step();
            cyc++;
        end while (term_valid !== 1'b1 && cyc < 20);
        chk({tag, ".gap"}, cyc, gap);
        chk({tag, ".term"}, term, et);
        chk({tag, ".index"}, index, ei);
        chk({tag, ".ovf"}, ovf, eo);
        chk({tag, ".busy"}, busy, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".alu_op"}, alu_op, OP_PASS);
        chk({tag, ".alu_a"}, alu_a, 0);
        chk({tag, ".alu_b"}, alu_b, 0);
        chk({tag, ".term"}, term, 0);
        chk({tag, ".index"}, index, 0);
        chk({tag, ".tv"}, term_valid, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".ovf"}, ovf, 0);
    endtask

    initial begin
        logic seen;

        step();
        step();
        rst = 1'b0;
        chk_reset_vals("rst0");

        // n=0: done next cycle, never busy, no pulse
        a0 = 4'd5; r = 4'd5; n_terms = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("n0.done", done, 1);
        chk("n0.busy", busy, 0);
        chk("n0.tv", term_valid, 0);
        chk("n0.alu_a", alu_a, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | term_valid | busy;
        end
        chk("n0.quiet", seen, 0);
        chk("n0.hold", done, 1);

        // a0=2 r=3 n=4
        a0 = 4'd2; r = 4'd3; n_terms = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        chk("s1.busy", busy, 1);
        chk("s1.done", done, 0);
        chk("s1.issue_a", alu_a, 2);
        wait_pulse("s1.p0", 1, 4'd2, 4'd0, 1'b0);
        wait_pulse("s1.p1", 6, 4'd5, 4'd1, 1'b0);
        wait_pulse("s1.p2", 6, 4'd8, 4'd2, 1'b0);
        wait_pulse("s1.p3", 6, 4'd11, 4'd3, 1'b0);
        step();
        chk("s1.done", done, 1);
        chk("s1.busy_end", busy, 0);
        chk("s1.term_hold", term, 11);
        chk("s1.ovf", ovf, 0);
        chk("s1.bus_idle", alu_op, OP_PASS);

        // a0=14 r=3 n=3, start held and inputs changed mid-sequence
        a0 = 4'd14; r = 4'd3; n_terms = 4'd3; start = 1'b1;
        step();
        chk("s2.busy", busy, 1);
        a0 = 4'd0; r = 4'd1; n_terms = 4'd2;
        wait_pulse("s2.p0", 1, 4'd14, 4'd0, 1'b0);
        wait_pulse("s2.p1", 6, 4'd1, 4'd1, 1'b1);
        wait_pulse("s2.p2", 6, 4'd4, 4'd2, 1'b1);
        step();
        chk("s2.done", done, 1);
        chk("s2.ovf_sticky", ovf, 1);
        // start still high in DONE: restart with a0=0 r=1 n=2
        step();
        start = 1'b0;
        chk("s3.busy", busy, 1);
        chk("s3.ovf_clr", ovf, 0);
        chk("s3.done", done, 0);
        wait_pulse("s3.p0", 1, 4'd0, 4'd0, 1'b0);
        wait_pulse("s3.p1", 6, 4'd1, 4'd1, 1'b0);
        step();
        chk("s3.done", done, 1);

        // r=0 a0=7 n=5
        a0 = 4'd7; r = 4'd0; n_terms = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        wait_pulse("s4.p0", 1, 4'd7, 4'd0, 1'b0);
        wait_pulse("s4.p1", 6, 4'd7, 4'd1, 1'b0);
        wait_pulse("s4.p2", 6, 4'd7, 4'd2, 1'b0);
        wait_pulse("s4.p3", 6, 4'd7, 4'd3, 1'b0);
        wait_pulse("s4.p4", 6, 4'd7, 4'd4, 1'b0);
        step();
        chk("s4.done", done, 1);
        chk("s4.ovf", ovf, 0);

        // reset mid-WAIT of second term
        a0 = 4'd14; r = 4'd3; n_terms = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        wait_pulse("s5.p0", 1, 4'd14, 4'd0, 1'b0);
        wait_pulse("s5.p1", 6, 4'd1, 4'd1, 1'b1);
        step();
        step();
        chk("s5.in_wait", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("s5.rst");
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen = seen | term_valid | busy | done;
        end
        chk("s5.quiet", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
